carregador_programa: RTL and testbench

- Writer side of the instruction ROM. Receives a program image as a byte stream (valid/ready) from a host or UART front end.
- Assembles little-endian 32-bit instruction words and drives the write port of the instruction memory.
- Holds the CPU in reset until the image is loaded and its checksum verifies.
- Sits between the serial receiver and the instruction memory; its output cpu_hold gates the core reset.

---
 rtl/carregador_programa.sv | 155 +++++++++++++++
 tb/tb_carregador_programa.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// Program loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes little-endian 32-bit words into instruction memory, holding the CPU until it verifies.
module carregador_programa #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load_start;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [15:0] word_idx;
    logic [7:0]  csum;
    logic [23:0] word_sr;

    logic [16:0] len_full;
    logic        last_word;

    assign len_full  = {1'b0, rx_data, len_lo};
    assign last_word = (word_idx + 16'd1) == len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        load_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_full > 17'(DEPTH)) state_nxt = S_ERROR;
                    else if (len_full == '0)   state_nxt = S_CHECK;
                    else                       state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3 && last_word) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_nxt  = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) begin
                    state_nxt  = S_LEN_LO;
                    load_start = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bytes shift in from the top so the first byte lands in bits [7:0] once the word is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo    <= '0;
            len       <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            csum      <= '0;
            word_sr   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (load_start) begin
                len_lo   <= '0;
                len      <= '0;
                byte_cnt <= '0;
                word_idx <= '0;
                csum     <= '0;
            end
            case (state)
                S_LEN_LO: begin
                    if (rx_valid) len_lo <= rx_data;
                end
                S_LEN_HI: begin
                    if (rx_valid) len <= {rx_data, len_lo};
                end
                S_DATA: begin
                    if (rx_valid) begin
                        word_sr  <= {rx_data, word_sr[23:8]};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {rx_data, word_sr};
                            mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx  <= word_idx + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: expected memory writes are queued as
// bytes are driven and matched against each mem_we pulse.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    carregador_programa #(
        .DEPTH(256),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    wr_t        exp_wr;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         spacing_on = 1'b0;
    bit         have_last = 1'b0;
    int         last_we_cyc = 0;
    logic [7:0] csum_model;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", mem_addr, mem_wdata);
            end
            if (sb.size() > 0) begin
                exp_wr = sb.pop_front();
                chk("wr_addr", mem_addr, exp_wr.addr);
                chk("wr_data", mem_wdata, exp_wr.data);
            end
            if (spacing_on) begin
                if (have_last) chk("wr_spacing", 32'(cyc - last_we_cyc), 32'd4);
                last_we_cyc = cyc;
                have_last   = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
        wr_t e;
        logic [7:0] b;
        e.addr = addr;
        e.data = w;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            csum_model = csum_model ^ b;
            send_byte(b);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_status(input logic d, input logic e);
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, d});
        chk("error", {31'd0, error}, {31'd0, e});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, ~d});
        chk("rx_ready_end", {31'd0, rx_ready}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic nominal_load();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        csum_model = 8'h00;
        send_word(32'h00A0_0513, 32'h0000_0000);
        send_word(32'h00B0_0593, 32'h0000_0004);
        send_byte(csum_model);
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("rst_mem_wdata", mem_wdata, 32'h0000_0000);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Nominal two-word program
        nominal_load();
        check_status(1'b1, 1'b0);
        idle(2);

        // Bad checksum: writes still happen, then error
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        csum_model = 8'h00;
        send_word(32'h00A0_0513, 32'h0000_0000);
        send_word(32'h00B0_0593, 32'h0000_0004);
        send_byte(8'h55);
        rx_valid = 1'b0;
        check_status(1'b0, 1'b1);
        idle(2);

        // Oversize length 257
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        rx_valid = 1'b0;
        check_status(1'b0, 1'b1);
        idle(5);

        // Zero length with stalls; start pulses mid-load must be ignored
        pulse_start();
        send_byte(8'h00);
        idle(5);
        pulse_start();
        send_byte(8'h00);
        idle(5);
        pulse_start();
        send_byte(8'h00);
        rx_valid = 1'b0;
        check_status(1'b1, 1'b0);
        idle(2);

        // Full depth, back-to-back bytes
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        csum_model = 8'h00;
        have_last  = 1'b0;
        spacing_on = 1'b1;
        for (int k = 0; k < 256; k++) send_word(32'(k), 32'(4 * k));
        send_byte(csum_model);
        rx_valid   = 1'b0;
        spacing_on = 1'b0;
        check_status(1'b1, 1'b0);
        idle(2);

        // Reset after 6 data bytes
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        csum_model = 8'h00;
        send_word(32'h1122_3344, 32'h0000_0000);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("mid_rst_mem_wdata", mem_wdata, 32'h0000_0000);
        chk("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_error", {31'd0, error}, 32'd0);
        chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        nominal_load();
        check_status(1'b1, 1'b0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
